rtc_bus_scheduler: RTL and testbench

- Sole owner of the RTC multiplexed bus pins (a_d, cs, rd, wr).
- Shares the bus between the write sequencer (the RTC write FSM) and the read sequencer (the RTC read FSM).
- Generates periodic time-refresh read requests.
- Arbitrates with write priority, inserts a bus-idle guard gap between transactions, and forces release on a stuck sequencer via a watchdog.

---
 rtl/rtc_bus_scheduler_if.sv | 34 +++
 rtl/rtc_bus_scheduler.sv | 142 ++++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_scheduler_if.sv
// Handshake and RTC bus pin bundle between the bus scheduler (master) and
// the write/read sequencers plus request logic (slave).
interface rtc_bus_scheduler_if;
    logic wr_req;
    logic wr_done;
    logic rd_done;
    logic do_it_esc;
    logic do_it_lee;
    logic gnt_wr;
    logic gnt_rd;
    logic a_d_esc, cs_esc, rd_esc, wr_esc;
    logic a_d_lee, cs_lee, rd_lee, wr_lee;
    logic a_d, cs, rd, wr;
    logic busy;
    logic timeout_err;

    modport master (
        input  wr_req, wr_done, rd_done,
        input  a_d_esc, cs_esc, rd_esc, wr_esc,
        input  a_d_lee, cs_lee, rd_lee, wr_lee,
        output do_it_esc, do_it_lee, gnt_wr, gnt_rd,
        output a_d, cs, rd, wr,
        output busy, timeout_err
    );

    modport slave (
        output wr_req, wr_done, rd_done,
        output a_d_esc, cs_esc, rd_esc, wr_esc,
        output a_d_lee, cs_lee, rd_lee, wr_lee,
        input  do_it_esc, do_it_lee, gnt_wr, gnt_rd,
        input  a_d, cs, rd, wr,
        input  busy, timeout_err
    );
endinterface

// File: rtl/rtc_bus_scheduler.sv
// Owns the RTC bus pins and time-shares them between the write and read sequencers.
// Optional macro RTC_RD_AFTER_WR_EN: a completed write immediately queues a read-back.
module rtc_bus_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 1000,
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 512,
    parameter int unsigned CNT_W          = 16
) (
    input logic                 clk,
    input logic                 reset,
    rtc_bus_scheduler_if.master bus_io
);

    typedef enum logic [1:0] {IDLE, GNT_WR, GNT_RD, GUARD} state_e;

    localparam int unsigned GUARD_W = ($clog2(GUARD_CYCLES) > 0) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST   = GUARD_W'(GUARD_CYCLES - 1);

    state_e             state_q, state_d;
    logic               pendWr_q, pendWr_d;
    logic               pendRd_q, pendRd_d;
    logic [CNT_W-1:0]   refreshCnt_q, refreshCnt_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic [GUARD_W-1:0] guardCnt_q, guardCnt_d;
    logic               doItEsc_q, doItLee_q;
    logic               timeoutErr_q, timeoutErr_d;
    logic               grantWr, grantRd;
    logic               ownerDone;
    logic               refreshWrap;
    logic               setRd;
    logic [3:0]         pins;

    // Only the current owner's done pulse can end a grant.
    assign ownerDone = (state_q == GNT_WR) ? bus_io.wr_done : bus_io.rd_done;

    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        guardCnt_d   = guardCnt_q;
        timeoutErr_d = timeoutErr_q;
        grantWr      = 1'b0;
        grantRd      = 1'b0;
        unique case (state_q)
            IDLE: begin
                wdog_d     = '0;
                guardCnt_d = '0;
                if (pendWr_q) begin
                    state_d = GNT_WR;
                    grantWr = 1'b1;
                end else if (pendRd_q) begin
                    state_d = GNT_RD;
                    grantRd = 1'b1;
                end
            end
            GNT_WR, GNT_RD: begin
                wdog_d = wdog_q + 1'b1;
                if (ownerDone) begin
                    state_d = GUARD;
                    wdog_d  = '0;
                end else if (wdog_q == TIMEOUT_LAST) begin
                    state_d      = GUARD;
                    wdog_d       = '0;
                    timeoutErr_d = 1'b1;
                end
            end
            GUARD: begin
                if (guardCnt_q == GUARD_LAST) begin
                    state_d    = IDLE;
                    guardCnt_d = '0;
                end else begin
                    guardCnt_d = guardCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef RTC_RD_AFTER_WR_EN
    logic wrCompleted;
    // wr_done outranks the watchdog in GNT_WR, so any wr_done seen here is a real completion.
    assign wrCompleted = (state_q == GNT_WR) && bus_io.wr_done;
`endif

    always_comb begin
        refreshWrap  = (refreshCnt_q == REFRESH_LAST);
        refreshCnt_d = refreshWrap ? '0 : refreshCnt_q + 1'b1;
        setRd        = refreshWrap;
`ifdef RTC_RD_AFTER_WR_EN
        if (wrCompleted) begin
            refreshCnt_d = '0;
            setRd        = 1'b1;
        end
`endif
        pendWr_d = (pendWr_q & ~grantWr) | bus_io.wr_req;
        pendRd_d = (pendRd_q & ~grantRd) | setRd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pendWr_q     <= 1'b0;
            pendRd_q     <= 1'b0;
            refreshCnt_q <= '0;
            wdog_q       <= '0;
            guardCnt_q   <= '0;
            doItEsc_q    <= 1'b0;
            doItLee_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pendWr_q     <= pendWr_d;
            pendRd_q     <= pendRd_d;
            refreshCnt_q <= refreshCnt_d;
            wdog_q       <= wdog_d;
            guardCnt_q   <= guardCnt_d;
            doItEsc_q    <= grantWr;
            doItLee_q    <= grantRd;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Pins follow the state register directly so an async reset idles the bus at once.
    always_comb begin
        pins = 4'b1111;
        if (state_q == GNT_WR) begin
            pins = {bus_io.a_d_esc, bus_io.cs_esc, bus_io.rd_esc, bus_io.wr_esc};
        end else if (state_q == GNT_RD) begin
            pins = {bus_io.a_d_lee, bus_io.cs_lee, bus_io.rd_lee, bus_io.wr_lee};
        end
    end

    assign {bus_io.a_d, bus_io.cs, bus_io.rd, bus_io.wr} = pins;
    assign bus_io.gnt_wr      = (state_q == GNT_WR);
    assign bus_io.gnt_rd      = (state_q == GNT_RD);
    assign bus_io.busy        = (state_q != IDLE);
    assign bus_io.do_it_esc   = doItEsc_q;
    assign bus_io.do_it_lee   = doItLee_q;
    assign bus_io.timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench for rtc_bus_scheduler (REFRESH=100, GUARD=4, TIMEOUT=300);
// covers both builds of RTC_RD_AFTER_WR_EN.
module tb_rtc_bus_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b0;

    rtc_bus_scheduler_if busIf ();

    rtc_bus_scheduler #(
        .REFRESH_CYCLES(100),
        .GUARD_CYCLES  (4),
        .TIMEOUT_CYCLES(300),
        .CNT_W         (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(busIf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] esc;
        logic [3:0] lee;
        logic [3:0] expWrOwner;
        logic [3:0] expRdOwner;
    } pinVec_t;

    typedef struct {
        bit isWr;
        int cyc;
    } grantExp_t;

    pinVec_t   vecs [8];
    grantExp_t expQ [$];
    int vectorCount = 0;
    int missCount   = 0;
    int cyc         = 0;
    int readStart   = 0;

    function automatic logic [3:0] busPins();
        return {busIf.a_d, busIf.cs, busIf.rd, busIf.wr};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wrReq, input logic wrDone, input logic rdDone);
        busIf.wr_req  = wrReq;
        busIf.wr_done = wrDone;
        busIf.rd_done = rdDone;
    endtask

    task automatic setStrobes(input logic [3:0] esc, input logic [3:0] lee);
        {busIf.a_d_esc, busIf.cs_esc, busIf.rd_esc, busIf.wr_esc} = esc;
        {busIf.a_d_lee, busIf.cs_lee, busIf.rd_lee, busIf.wr_lee} = lee;
    endtask

    task automatic expectGrant(input bit isWr, input int atCycle);
        grantExp_t e;
        e.isWr = isWr;
        e.cyc  = atCycle;
        expQ.push_back(e);
    endtask

    // Advance one cycle and score any start pulse against the expected-grant queue.
    task automatic nextCycle();
        grantExp_t e;
        @(posedge clk);
        #1;
        cyc++;
        checkOutput("single_grant", {31'd0, busIf.gnt_wr & busIf.gnt_rd}, 32'd0);
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            e = expQ.pop_front();
            vectorCount++;
            missCount++;
            $display("[TB] FAIL missing_do_it: got no start pulse by cycle %0d, want %s at cycle %0d",
                     cyc, e.isWr ? "do_it_esc" : "do_it_lee", e.cyc);
        end
        if (busIf.do_it_esc || busIf.do_it_lee) begin
            if (expQ.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL unexpected_do_it at cycle %0d: got esc=%b lee=%b, want none",
                         cyc, busIf.do_it_esc, busIf.do_it_lee);
            end else begin
                e = expQ.pop_front();
                checkOutput("do_it_cycle", cyc, e.cyc);
                checkOutput("do_it_esc", {31'd0, busIf.do_it_esc}, {31'd0, e.isWr});
                checkOutput("do_it_lee", {31'd0, busIf.do_it_lee}, {31'd0, !e.isWr});
                checkOutput("do_it_gnt", {30'd0, busIf.gnt_wr, busIf.gnt_rd}, e.isWr ? 32'd2 : 32'd1);
            end
        end
    endtask

    task automatic runTo(input int target);
        while (cyc < target) nextCycle();
    endtask

    task automatic pulse(input logic wrReq, input logic wrDone, input logic rdDone);
        applyStimulus(wrReq, wrDone, rdDone);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
        vecs[1] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
        vecs[2] = '{4'b1010, 4'b0101, 4'b1010, 4'b0101};
        vecs[3] = '{4'b0101, 4'b1010, 4'b0101, 4'b1010};
        vecs[4] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
        vecs[5] = '{4'b0100, 4'b0010, 4'b0100, 4'b0010};
        vecs[6] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
        vecs[7] = '{4'b1110, 4'b0111, 4'b1110, 4'b0111};

        applyStimulus(1'b0, 1'b0, 1'b0);
        setStrobes(4'b0000, 4'b0000);
        #2 reset = 1'b1;
        #12;
        checkOutput("rst_pins", busPins(), 4'b1111);
        checkOutput("rst_flags", {busIf.gnt_wr, busIf.gnt_rd, busIf.busy, busIf.timeout_err}, 4'b0000);
        checkOutput("rst_do_it", {busIf.do_it_esc, busIf.do_it_lee}, 2'b00);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
        checkOutput("c0_busy", busIf.busy, 1'b0);

        // First refresh read: pend at 99, decision at 100, grant at 101.
        expectGrant(1'b0, 101);
        runTo(100);
        checkOutput("pre_rd_busy", busIf.busy, 1'b0);
        checkOutput("pre_rd_gnt", busIf.gnt_rd, 1'b0);
        runTo(101);
        checkOutput("rd_gnt", {busIf.gnt_wr, busIf.gnt_rd, busIf.busy}, 3'b011);
        for (int i = 0; i < 8; i++) begin
            setStrobes(vecs[i].esc, vecs[i].lee);
            #1;
            checkOutput("rd_owner_pins", busPins(), vecs[i].expRdOwner);
            nextCycle();
        end
        setStrobes(4'b0000, 4'b0000);
        runTo(200);
        pulse(1'b0, 1'b1, 1'b0);
        checkOutput("wr_done_ignored", {busIf.gnt_wr, busIf.gnt_rd, busIf.busy}, 3'b011);
        runTo(347);
        checkOutput("rd_still_owned", busIf.gnt_rd, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        checkOutput("guard_pins", busPins(), 4'b1111);
        checkOutput("guard_flags", {busIf.gnt_wr, busIf.gnt_rd, busIf.busy}, 3'b001);
        runTo(351);
        checkOutput("guard_end_pins", busPins(), 4'b1111);
        checkOutput("guard_end_busy", busIf.busy, 1'b1);

        // Write request lands alongside the pending refresh: write wins.
        expectGrant(1'b1, 353);
        pulse(1'b1, 1'b0, 1'b0);
        checkOutput("idle_busy", busIf.busy, 1'b0);
        runTo(353);
        checkOutput("wr_first", {busIf.gnt_wr, busIf.gnt_rd}, 2'b10);
        for (int i = 0; i < 8; i++) begin
            setStrobes(vecs[i].esc, vecs[i].lee);
            #1;
            checkOutput("wr_owner_pins", busPins(), vecs[i].expWrOwner);
            nextCycle();
        end
        setStrobes(4'b0000, 4'b0000);
        runTo(373);
        expectGrant(1'b0, 379);
        pulse(1'b0, 1'b1, 1'b0);
        runTo(377);
        checkOutput("wr_guard", {busIf.gnt_wr, busIf.gnt_rd, busIf.busy}, 3'b001);
        runTo(378);
        checkOutput("wr_guard_done", busIf.busy, 1'b0);
        runTo(379);
        checkOutput("rd_after_wr", {busIf.gnt_wr, busIf.gnt_rd}, 2'b01);

        // Write requests during a read wait their turn and merge into one sequence.
        runTo(385);
        pulse(1'b1, 1'b0, 1'b0);
        checkOutput("no_preempt1", {busIf.gnt_wr, busIf.gnt_rd}, 2'b01);
        runTo(390);
        pulse(1'b1, 1'b0, 1'b0);
        checkOutput("no_preempt2", {busIf.gnt_wr, busIf.gnt_rd}, 2'b01);
        runTo(420);
        expectGrant(1'b1, 426);
        pulse(1'b0, 1'b0, 1'b1);
        runTo(425);
        checkOutput("wr_wait_idle", {busIf.gnt_wr, busIf.busy}, 2'b00);
        runTo(426);
        checkOutput("wr_granted", busIf.gnt_wr, 1'b1);

        // Write sequencer never finishes: watchdog releases after 300 cycles.
        runTo(725);
        checkOutput("wdog_hold", {busIf.gnt_wr, busIf.timeout_err}, 2'b10);
        expectGrant(1'b0, 731);
        runTo(726);
        checkOutput("wdog_fire", {busIf.gnt_wr, busIf.busy, busIf.timeout_err}, 3'b011);
        runTo(731);
        checkOutput("rd_after_to", {busIf.gnt_rd, busIf.timeout_err}, 2'b11);
        runTo(740);
        pulse(1'b0, 1'b0, 1'b1);
        runTo(745);
        checkOutput("to_sticky", {busIf.busy, busIf.timeout_err}, 2'b01);

        // Completed write followed by read-back (feature) or by the natural refresh.
        runTo(746);
        expectGrant(1'b1, 748);
        pulse(1'b1, 1'b0, 1'b0);
        runTo(750);
        pulse(1'b0, 1'b1, 1'b0);
`ifdef RTC_RD_AFTER_WR_EN
        expectGrant(1'b0, 756);
        runTo(755);
        checkOutput("rb_idle", busIf.busy, 1'b0);
        runTo(756);
        checkOutput("rb_gnt", busIf.gnt_rd, 1'b1);
        runTo(760);
        pulse(1'b0, 1'b0, 1'b1);
        expectGrant(1'b0, 852);
        runTo(850);
        checkOutput("restart_idle", busIf.busy, 1'b0);
        runTo(851);
        checkOutput("restart_pre", {busIf.gnt_rd, busIf.busy}, 2'b00);
        runTo(852);
        checkOutput("restart_gnt", busIf.gnt_rd, 1'b1);
        readStart = 852;
`else
        expectGrant(1'b0, 801);
        runTo(756);
        checkOutput("no_rb", {busIf.gnt_rd, busIf.busy}, 2'b00);
        runTo(800);
        checkOutput("no_rb_late", {busIf.gnt_rd, busIf.busy}, 2'b00);
        runTo(801);
        checkOutput("wrap_gnt", busIf.gnt_rd, 1'b1);
        readStart = 801;
`endif

        // Reset in the middle of a read grant, with a write left pending.
        runTo(readStart + 2);
        setStrobes(4'b1111, 4'b0000);
        #1;
        checkOutput("pre_rst_pins", busPins(), 4'b0000);
        pulse(1'b1, 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        checkOutput("async_rst_pins", busPins(), 4'b1111);
        checkOutput("async_rst_flags", {busIf.gnt_wr, busIf.gnt_rd, busIf.busy, busIf.timeout_err}, 4'b0000);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
        runTo(20);
        checkOutput("pend_lost", {busIf.gnt_wr, busIf.gnt_rd, busIf.busy}, 3'b000);
        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
